// File: rtl/aes_round_scheduler_pkg.sv
// Shared constants for the AES round scheduler: datapath round kinds, FSM
// state encodings and the Nk -> Nr relation.
package aes_round_scheduler_pkg;

   localparam logic [1:0] KIND_INIT  = 2'd0;
   localparam logic [1:0] KIND_MID   = 2'd1;
   localparam logic [1:0] KIND_FINAL = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int nr_of_nk(input int nk);
      return nk + 6;
   endfunction

endpackage

// File: rtl/aes_round_scheduler_if.sv
// Request, response and round-datapath signals between the host side and the
// scheduler; master is the host/datapath side, slave is the scheduler.
interface aes_round_scheduler_if #(
   parameter int RW = 4
);

   logic          req0_valid;
   logic [127:0]  req0_data;
   logic          req0_ready;
   logic          req1_valid;
   logic [127:0]  req1_data;
   logic          req1_ready;
   logic [127:0]  dp_in;
   logic [1:0]    dp_kind;
   logic [RW-1:0] dp_key_idx;
   logic [127:0]  dp_result;
   logic          resp_valid;
   logic [127:0]  resp_data;
   logic          resp_id;
   logic          resp_ready;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, resp_ready, dp_result,
      input  req0_ready, req1_ready, resp_valid, resp_data, resp_id,
             dp_in, dp_kind, dp_key_idx
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, resp_ready, dp_result,
      output req0_ready, req1_ready, resp_valid, resp_data, resp_id,
             dp_in, dp_kind, dp_key_idx
   );

endinterface

// File: rtl/aes_round_scheduler_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that did not win last time.
module aes_round_scheduler_rr_arbiter2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant,
   output logic any
);

   assign any   = valid0 | valid1;
   assign grant = (valid0 & valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/aes_round_scheduler.sv
// Sequences one shared iterative AES round datapath: arbitrates two
// requesters, runs Nr+1 rounds per block and returns the ciphertext with its id.
module aes_round_scheduler
   import aes_round_scheduler_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic busy,
   aes_round_scheduler_if.slave bus
);

   localparam int RW = $clog2(Nr + 1);
   localparam logic [RW-1:0] LAST = RW'(Nr);

   if (Nr != nr_of_nk(Nk)) begin : g_bad_cfg
      $error("aes_round_scheduler: Nr must equal Nk+6");
   end

   logic [1:0]    state;
   logic [RW-1:0] round;
   logic [127:0]  blk;
   logic          resp_id;
   logic          resp_valid;
   logic          last_grant;
   logic          grant;
   logic          any;
   logic          accept;

   aes_round_scheduler_rr_arbiter2 u_arb (
      .valid0     (bus.req0_valid),
      .valid1     (bus.req1_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .any        (any)
   );

   // clear in IDLE suppresses the accept for that cycle
   assign accept         = (state == ST_IDLE) && any && !clear;
   assign bus.req0_ready = accept && !grant && bus.req0_valid;
   assign bus.req1_ready = accept &&  grant && bus.req1_valid;

   always_comb begin
      bus.dp_kind    = KIND_INIT;
      bus.dp_key_idx = '0;
      if (state == ST_RUN) begin
         bus.dp_key_idx = round;
         if (round == LAST)
            bus.dp_kind = KIND_FINAL;
         else if (round != '0)
            bus.dp_kind = KIND_MID;
      end
   end

   assign bus.dp_in      = blk;
   assign bus.resp_data  = blk;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_id    = resp_id;
   assign busy           = (state == ST_RUN) || (state == ST_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         round      <= '0;
         blk        <= '0;
         resp_id    <= 1'b0;
         resp_valid <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  blk        <= grant ? bus.req1_data : bus.req0_data;
                  resp_id    <= grant;
                  last_grant <= grant;
                  round      <= '0;
                  state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (clear) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
               end else begin
                  blk <= bus.dp_result;
                  // round parks at Nr after the final round instead of wrapping
                  if (round == LAST) begin
                     state      <= ST_DONE;
                     resp_valid <= 1'b1;
                  end else begin
                     round <= round + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (clear || bus.resp_ready) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: combinational AES round datapath and key
// expansion around three scheduler instances (AES-128/192/256).
module tb_aes_round_scheduler;
   import aes_round_scheduler_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear4 = 1'b0;
   logic clear_off = 1'b0;
   logic busy4, busy6, busy8;
   int   n_vec = 0;
   int   n_miss = 0;
   int   viol = 0;

   logic [7:0]   sbox [256];
   logic [127:0] rk [3][15];

   aes_round_scheduler_if #(.RW(4)) b4 ();
   aes_round_scheduler_if #(.RW(4)) b6 ();
   aes_round_scheduler_if #(.RW(4)) b8 ();

   aes_round_scheduler #(.Nk(4), .Nr(10)) u_d4 (
      .clk(clk), .reset(reset), .clear(clear4), .busy(busy4), .bus(b4));
   aes_round_scheduler #(.Nk(6), .Nr(12)) u_d6 (
      .clk(clk), .reset(reset), .clear(clear_off), .busy(busy6), .bus(b6));
   aes_round_scheduler #(.Nk(8), .Nr(14)) u_d8 (
      .clk(clk), .reset(reset), .clear(clear_off), .busy(busy8), .bus(b8));

   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xt(a);
      end
      return p;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [1:0] kind,
                                             input logic [127:0] key);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [7:0]   x0, x1, x2, x3;
      logic [127:0] o;
      if (kind == KIND_INIT) return s ^ key;
      for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[4*c+r] = a[4*((c+r)%4)+r];
      if (kind == KIND_MID) begin
         for (int c = 0; c < 4; c++) begin
            x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
            b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
            b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
            b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
            b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
      return o ^ key;
   endfunction

   function automatic logic [127:0] ref_enc(input int cfg, input logic [127:0] pt);
      logic [127:0] s;
      int nr;
      nr = 10 + 2 * cfg;
      s = pt ^ rk[cfg][0];
      for (int r = 1; r < nr; r++) s = round_fn(s, KIND_MID, rk[cfg][r]);
      return round_fn(s, KIND_FINAL, rk[cfg][nr]);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic expand(input int cfg, input int nk, input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon;
      int nr;
      nr = nk + 6;
      rcon = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk[cfg][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   assign b4.dp_result = round_fn(b4.dp_in, b4.dp_kind, rk[0][b4.dp_key_idx]);
   assign b6.dp_result = round_fn(b6.dp_in, b6.dp_kind, rk[1][b6.dp_key_idx]);
   assign b8.dp_result = round_fn(b8.dp_in, b8.dp_kind, rk[2][b8.dp_key_idx]);

   always @(negedge clk) begin
      if (b4.req0_ready && b4.req1_ready) viol++;
      if (busy4 && (b4.req0_ready || b4.req1_ready)) viol++;
   end

   task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_one(input int who, input logic [127:0] pt);
      int g;
      if (who == 0) begin b4.req0_data = pt; b4.req0_valid = 1'b1; end
      else          begin b4.req1_data = pt; b4.req1_valid = 1'b1; end
      #1;
      g = 0;
      while (!(who == 0 ? b4.req0_ready : b4.req1_ready) && g < 40) begin
         tick();
         g++;
      end
      expect_eq("accept_seen", 128'(g < 40), 128'(1));
      tick();
      if (who == 0) begin b4.req0_valid = 1'b0; b4.req0_data = rnd128(); end
      else          begin b4.req1_valid = 1'b0; b4.req1_data = rnd128(); end
   endtask

   task automatic wait_resp(output int lat);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (b4.resp_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] pt, p0, p1;
      logic [7:0]   inv, p;
      int lat, lat4, lat6, lat8, who, seen, g;

      for (int x = 0; x < 256; x++) begin
         inv = 8'h01;
         p = 8'(x);
         for (int e = 0; e < 8; e++) begin
            if (e != 0) inv = gmul(inv, p);
            p = gmul(p, p);
         end
         sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      expand(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
      expand(1, 6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
      expand(2, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

      b4.req0_valid = 0; b4.req1_valid = 0; b4.req0_data = '0; b4.req1_data = '0; b4.resp_ready = 1;
      b6.req0_valid = 0; b6.req1_valid = 0; b6.req0_data = '0; b6.req1_data = '0; b6.resp_ready = 1;
      b8.req0_valid = 0; b8.req1_valid = 0; b8.req0_data = '0; b8.req1_data = '0; b8.resp_ready = 1;

      // reset values
      #12;
      expect_eq("rst_ctl", 128'({b4.resp_valid, b4.resp_id, busy4, busy6, busy8,
                                 b4.req0_ready, b4.req1_ready, b4.dp_kind, b4.dp_key_idx}), 128'(0));
      expect_eq("rst_data", b4.resp_data, 128'h0);
      reset = 1'b0;
      tick();

      // known-answer blocks on all three key sizes at once
      pt = 128'h00112233445566778899aabbccddeeff;
      b4.req0_data = pt; b6.req0_data = pt; b8.req0_data = pt;
      b4.req0_valid = 1; b6.req0_valid = 1; b8.req0_valid = 1;
      #1;
      expect_eq("kat_ready", 128'({b4.req0_ready, b4.req1_ready, b6.req0_ready, b8.req0_ready}), 128'(4'b1011));
      tick();
      b4.req0_valid = 0; b6.req0_valid = 0; b8.req0_valid = 0;
      b4.req0_data = rnd128(); b6.req0_data = rnd128(); b8.req0_data = rnd128();
      expect_eq("kind_init", 128'({b4.dp_kind, b4.dp_key_idx}), 128'({KIND_INIT, 4'd0}));
      lat4 = -1; lat6 = -1; lat8 = -1;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (c == 5)  expect_eq("kind_mid", 128'({b4.dp_kind, b4.dp_key_idx}), 128'({KIND_MID, 4'd5}));
         if (c == 10) expect_eq("kind_final", 128'({b4.dp_kind, b4.dp_key_idx}), 128'({KIND_FINAL, 4'd10}));
         if (b4.resp_valid && lat4 < 0) begin
            lat4 = c;
            expect_eq("kat128", b4.resp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
            expect_eq("kat128_id", 128'(b4.resp_id), 128'(0));
         end
         if (b6.resp_valid && lat6 < 0) begin
            lat6 = c;
            expect_eq("kat192", b6.resp_data, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
         end
         if (b8.resp_valid && lat8 < 0) begin
            lat8 = c;
            expect_eq("kat256", b8.resp_data, 128'h8ea2b7ca516745bfeafc49904b496089);
         end
      end
      expect_eq("lat128", 128'(lat4), 128'(11));
      expect_eq("lat192", 128'(lat6), 128'(13));
      expect_eq("lat256", 128'(lat8), 128'(15));
      expect_eq("idle_after", 128'({busy4, busy6, busy8, b4.resp_valid}), 128'(0));

      // round-robin with both requesters valid from reset, random key and data
      expand(0, 4, {rnd128(), 128'h0});
      reset = 1'b1;
      #1;
      reset = 1'b0;
      p0 = rnd128(); p1 = rnd128();
      b4.req0_data = p0; b4.req1_data = p1;
      b4.req0_valid = 1; b4.req1_valid = 1;
      #1;
      for (int k = 0; k < 8; k++) begin
         g = 0;
         while (!(b4.req0_ready || b4.req1_ready) && g < 40) begin
            tick();
            g++;
         end
         who = b4.req1_ready ? 1 : 0;
         expect_eq("rr_grant", 128'(who), 128'(k % 2));
         pt = who ? p1 : p0;
         tick();
         if (who == 1) begin p1 = rnd128(); b4.req1_data = p1; end
         else          begin p0 = rnd128(); b4.req0_data = p0; end
         wait_resp(lat);
         expect_eq("rr_data", b4.resp_data, ref_enc(0, pt));
         expect_eq("rr_id", 128'(b4.resp_id), 128'(k % 2));
         expect_eq("rr_lat", 128'(lat), 128'(11));
      end
      b4.req0_valid = 0; b4.req1_valid = 0;
      tick();

      // consumer stalls for 20 clocks with both requesters pending
      b4.resp_ready = 0;
      pt = rnd128();
      accept_one(0, pt);
      wait_resp(lat);
      b4.req0_valid = 1; b4.req1_valid = 1;
      for (int c = 0; c < 20; c++) begin
         #1;
         expect_eq("hold_data", b4.resp_data, ref_enc(0, pt));
         expect_eq("hold_ctl", 128'({b4.resp_valid, busy4, b4.req0_ready, b4.req1_ready, b4.resp_id}),
                   128'(5'b11000));
         tick();
      end
      b4.req0_valid = 0; b4.req1_valid = 0; b4.resp_ready = 1;
      tick();
      expect_eq("hold_release", 128'({busy4, b4.resp_valid}), 128'(0));

      // abort at round 5, then clear versus accept in IDLE
      pt = rnd128();
      accept_one(1, pt);
      repeat (5) tick();
      expect_eq("clr_round5", 128'({b4.dp_kind, b4.dp_key_idx}), 128'({KIND_MID, 4'd5}));
      clear4 = 1;
      tick();
      clear4 = 0;
      expect_eq("clr_idle", 128'({busy4, b4.resp_valid}), 128'(0));
      b4.req0_valid = 1; clear4 = 1;
      #1;
      expect_eq("clr_prio", 128'({b4.req0_ready, b4.req1_ready}), 128'(0));
      tick();
      clear4 = 0; b4.req0_valid = 0;
      expect_eq("clr_noacc", 128'(busy4), 128'(0));
      seen = 0;
      repeat (20) begin
         tick();
         if (b4.resp_valid) seen++;
      end
      expect_eq("clr_noresp", 128'(seen), 128'(0));
      p0 = rnd128(); p1 = rnd128();
      b4.req0_data = p0; b4.req1_data = p1; b4.req0_valid = 1; b4.req1_valid = 1;
      #1;
      expect_eq("clr_rr", 128'({b4.req0_ready, b4.req1_ready}), 128'(2'b10));
      tick();
      b4.req0_valid = 0; b4.req1_valid = 0;
      wait_resp(lat);
      expect_eq("clr_next", b4.resp_data, ref_enc(0, p0));
      expect_eq("clr_next_id", 128'(b4.resp_id), 128'(0));
      expect_eq("clr_next_lat", 128'(lat), 128'(11));
      tick();

      // asynchronous reset at round 3, then a clean restart
      pt = rnd128();
      accept_one(1, pt);
      repeat (3) tick();
      expect_eq("rst_round3", 128'({b4.resp_id, busy4, b4.dp_key_idx}), 128'({2'b11, 4'd3}));
      #1;
      reset = 1'b1;
      #1;
      expect_eq("rst_async", 128'({b4.resp_valid, b4.resp_id, busy4, b4.dp_kind, b4.dp_key_idx}), 128'(0));
      expect_eq("rst_async_data", b4.resp_data, 128'h0);
      #1;
      reset = 1'b0;
      tick();
      pt = rnd128();
      accept_one(0, pt);
      wait_resp(lat);
      expect_eq("restart_data", b4.resp_data, ref_enc(0, pt));
      expect_eq("restart_lat", 128'(lat), 128'(11));
      tick();

      expect_eq("ready_rules", 128'(viol), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
